// File: rtl/message_receiver.sv
// Serial message receiver: mid-bit samples a start/message/pad frame and presents the message.
// Result pulse (msg_valid or frame_err) comes one cycle after the final sample; no backpressure, the consumer must take each pulse.
module message_receiver #(
  parameter int BIT_PERIOD = 1024,
  parameter int MSG_W      = 5,
  parameter int FRAME_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ser_in,
  output logic [MSG_W-1:0] msg_out,
  output logic             msg_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [PW-1:0] HALF_LAST  = PW'(BIT_PERIOD / 2 - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] MSG_LAST   = BW'(MSG_W);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam bit            NO_PAD     = (FRAME_BITS == MSG_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    PAD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, ser_s_q, ser_d_q;
  logic [PW-1:0]    per_cnt_q, per_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [MSG_W:0]   shift_ext;
  logic             pad_err_q, pad_err_d;
  logic [MSG_W-1:0] msg_out_q, msg_out_d;
  logic             msg_valid_q, msg_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             tick;
  logic             rise;

  assign rise = ser_s_q & ~ser_d_q;

  // Sample strobe: half a bit into the start bit, then once per full bit period.
  always_comb begin
    tick = 1'b0;
    case (state_q)
      START_CHK: tick = (per_cnt_q == HALF_LAST);
      DATA, PAD: tick = (per_cnt_q == PER_LAST);
      default:   tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      ser_s_q <= 1'b0;
      ser_d_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync1_q <= ser_in;
      ser_s_q <= sync1_q;
      ser_d_q <= ser_s_q;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en && rise) state_d = START_CHK;
      end
      START_CHK: begin
        if (tick) state_d = ser_s_q ? DATA : IDLE;
      end
      DATA: begin
        if (tick && (bit_cnt_q == MSG_LAST)) state_d = NO_PAD ? DONE : PAD;
      end
      PAD: begin
        if (tick && (bit_cnt_q == FRAME_LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: period/bit counters, message shift register, sticky pad error.
  always_comb begin
    per_cnt_d = per_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pad_err_d = pad_err_q;
    shift_ext = {shift_q, ser_s_q};
    case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        bit_cnt_d = '0;
      end
      START_CHK: begin
        if (tick) begin
          per_cnt_d = '0;
          bit_cnt_d = ser_s_q ? BW'(1) : '0;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      DATA, PAD: begin
        if (tick) begin
          per_cnt_d = '0;
          bit_cnt_d = (bit_cnt_q == FRAME_LAST) ? '0 : bit_cnt_q + BW'(1);
          if (state_q == DATA) shift_d = shift_ext[MSG_W-1:0];
          else                 pad_err_d = pad_err_q | ser_s_q;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      DONE: begin
        per_cnt_d = '0;
        bit_cnt_d = '0;
        pad_err_d = 1'b0;
      end
      default: begin
        per_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    msg_valid_d = (state_q == DONE) && !pad_err_q;
    frame_err_d = (state_q == DONE) && pad_err_q;
    msg_out_d   = msg_valid_d ? shift_q : msg_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pad_err_q   <= 1'b0;
      msg_out_q   <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pad_err_q   <= pad_err_d;
      msg_out_q   <= msg_out_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign msg_out   = msg_out_q;
  assign msg_valid = msg_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_message_receiver.sv
// Directed bench for message_receiver: frame table plus hand sequences for reset, glitch and back-to-back cases.
module tb_message_receiver;
  localparam int BP = 8;
  localparam int MW = 5;
  localparam int FB = 10;
  localparam int PULSE_LAT = 79;  // first start-bit edge to pulse: 2 sync + 77

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          ser_in;
  logic [MW-1:0] msg_out;
  logic          msg_valid;
  logic          frame_err;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_pulse_cyc = -1;
  int overlap = 0;
  int wide = 0;
  int busy_hits = 0;
  logic prev_pulse = 1'b0;
  logic [MW-1:0] vq[$];

  typedef struct {
    string         name;
    logic [FB-1:0] frame;
    int            en_mode;  // 0: en high, 1: en low, 2: en dropped mid-frame
    logic          exp_valid;
    logic          exp_err;
    logic [MW-1:0] exp_msg;
  } vec_t;

  vec_t vecs[7];

  message_receiver #(.BIT_PERIOD(BP), .MSG_W(MW), .FRAME_BITS(FB)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ser_in   (ser_in),
    .msg_out  (msg_out),
    .msg_valid(msg_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (msg_valid) begin
      n_valid++;
      last_pulse_cyc = cyc;
      vq.push_back(msg_out);
    end
    if (frame_err) begin
      n_err++;
      last_pulse_cyc = cyc;
    end
    if (msg_valid && frame_err) overlap++;
    if ((msg_valid || frame_err) && prev_pulse) wide++;
    prev_pulse = msg_valid || frame_err;
    if (busy) busy_hits++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called and returns on a falling edge; each bit held BP clocks.
  task automatic send_frame(input logic [FB-1:0] f, input int en_mode, input int nbits);
    en = (en_mode != 1);
    for (int i = 0; i < nbits * BP; i++) begin
      if (i % BP == 0) ser_in = f[FB-1-i/BP];
      if (en_mode == 2 && i == 2 * BP) en = 1'b0;
      @(negedge clk);
    end
    ser_in = 1'b0;
    en = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [FB-1:0] f, input int en_mode,
                           input logic exp_valid, input logic exp_err, input logic [MW-1:0] exp_msg);
    int nv, ne, e1;
    nv = n_valid;
    ne = n_err;
    e1 = cyc + 1;
    send_frame(f, en_mode, FB);
    repeat (4) @(negedge clk);
    check({name, "_valid_cnt"}, n_valid - nv, 32'(exp_valid));
    check({name, "_err_cnt"}, n_err - ne, 32'(exp_err));
    check({name, "_msg_out"}, 32'(msg_out), 32'(exp_msg));
    if (exp_valid || exp_err) check({name, "_latency"}, last_pulse_cyc - e1, PULSE_LAT);
  endtask

  initial begin
    int nv, ne, e1;

    vecs[0] = '{"good_10110", 10'b1_10110_0000, 0, 1'b1, 1'b0, 5'b10110};
    vecs[1] = '{"pad7_err",   10'b1_10110_0100, 0, 1'b0, 1'b1, 5'b10110};
    vecs[2] = '{"good_01011", 10'b1_01011_0000, 0, 1'b1, 1'b0, 5'b01011};
    vecs[3] = '{"pad9_err",   10'b1_11100_0001, 0, 1'b0, 1'b1, 5'b01011};
    vecs[4] = '{"pad6_err",   10'b1_00011_1000, 0, 1'b0, 1'b1, 5'b01011};
    vecs[5] = '{"en_off",     10'b1_10001_0000, 1, 1'b0, 1'b0, 5'b01011};
    vecs[6] = '{"en_drop",    10'b1_10001_0000, 2, 1'b1, 1'b0, 5'b10001};

    // Reset and idle line
    reset = 1'b0;
    en = 1'b1;
    ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_msg_out", 32'(msg_out), 0);
    check("rst_valid", 32'(msg_valid), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_valid_cnt", n_valid, 0);
    check("idle_err_cnt", n_err, 0);
    check("idle_busy_hits", busy_hits, 0);
    check("idle_msg_out", 32'(msg_out), 0);

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].frame, vecs[i].en_mode,
                vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_msg);

    // Two-clock glitch: START_CHK sees 0 at mid-bit and drops back to IDLE
    nv = n_valid;
    ne = n_err;
    e1 = cyc + 1;
    ser_in = 1'b1;
    repeat (2) @(negedge clk);
    ser_in = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_t0p3", 32'(busy), 1);
    check("glitch_cyc_ref", cyc - e1, 5);
    @(negedge clk);
    check("glitch_idle_t0p4", 32'(busy), 0);
    repeat (2) @(negedge clk);
    check("glitch_valid_cnt", n_valid - nv, 0);
    check("glitch_err_cnt", n_err - ne, 0);
    run_frame("after_glitch", 10'b1_00001_0000, 0, 1'b1, 1'b0, 5'b00001);

    // Back-to-back frames with no gap past the pad bits
    nv = n_valid;
    send_frame(10'b1_11111_0000, 0, FB);
    send_frame(10'b1_00000_0000, 0, FB);
    repeat (4) @(negedge clk);
    check("b2b_valid_cnt", n_valid - nv, 2);
    if (vq.size() >= 2) begin
      check("b2b_first_msg", 32'(vq[vq.size()-2]), 32'(5'b11111));
      check("b2b_second_msg", 32'(vq[vq.size()-1]), 32'(5'b00000));
    end else begin
      check("b2b_queue_depth", vq.size(), 2);
    end

    // Reset in the middle of DATA aborts the frame without a pulse
    run_frame("pre_reset", 10'b1_11011_0000, 0, 1'b1, 1'b0, 5'b11011);
    nv = n_valid;
    ne = n_err;
    send_frame(10'b1_10101_0000, 0, 4);
    check("mid_busy_before_rst", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_msg_out", 32'(msg_out), 0);
    check("mid_rst_valid", 32'(msg_valid), 0);
    ser_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_rst_valid_cnt", n_valid - nv, 0);
    check("mid_rst_err_cnt", n_err - ne, 0);
    run_frame("after_reset", 10'b1_01010_0000, 0, 1'b1, 1'b0, 5'b01010);

    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/message_receiver.md
Name: message_receiver

Overview:
- Serial receive end of the message link; the counterpart of the message transmit datapath.
- The transmit side holds each frame bit on the line for BIT_PERIOD clocks. This block recovers the bits by mid-bit sampling and reassembles the MSG_W-bit message.
- Presents the message with a one-cycle valid pulse and flags malformed frames.
- Sits between the serial line input and the message consumer logic.

Parameters:
- BIT_PERIOD, 1024, clocks per serial bit; must be an even number ≥ 4.
- MSG_W, 5, message width in bits.
- FRAME_BITS, 10, total bits per frame: 1 start + MSG_W message + (FRAME_BITS-1-MSG_W) pad bits; must satisfy FRAME_BITS ≥ MSG_W+1.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- reset, input, 1, asynchronous active-low reset.
- en, input, 1, receive enable; when 0, IDLE does not accept new start bits.
- ser_in, input, 1, asynchronous serial line; idles at 0.
- msg_out, output, MSG_W, last correctly received message.
- msg_valid, output, 1, one-cycle pulse when msg_out updates.
- frame_err, output, 1, one-cycle pulse when a frame has a nonzero pad bit.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on port reset. The clock port is clk.
- Reset values: msg_out=0, msg_valid=0, frame_err=0, busy=0, state=IDLE, all counters=0, synchronizer flops=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No valid or error pulse is produced.
- Input synchronization: ser_in passes through a 2-flop synchronizer to give ser_s. A third flop holds ser_d, the previous value of ser_s. All decisions use ser_s.
- Frame format, in time order:
  - bit 0: start bit, value 1.
  - bits 1..MSG_W: message, MSB first.
  - remaining bits: pad, required value 0.
- Timing: cycle t0 is the clock edge where state=IDLE, en=1, ser_s=1 and ser_d=0.
- Bit counter bit_cnt has width clog2(FRAME_BITS). Period counter per_cnt has width clog2(BIT_PERIOD).
- FSM states and transitions:
  - IDLE: per_cnt=0, bit_cnt=0. On a rising edge of ser_s with en=1, go to START_CHK. en is ignored once the block has left IDLE.
  - START_CHK: count BIT_PERIOD/2-1 further clocks, so the sample occurs at t0+BIT_PERIOD/2.
    - If ser_s=1 there: go to DATA with bit_cnt=1 and per_cnt cleared.
    - If ser_s=0: false start; return to IDLE with no pulse.
  - DATA: sample ser_s every BIT_PERIOD clocks, at t0+BIT_PERIOD/2+k*BIT_PERIOD for k=1..MSG_W.
    - Each sample is shifted into a MSG_W shift register from the LSB end, so the first bit received ends up at the MSB.
    - bit_cnt increments per sample.
    - After sample k=MSG_W: go to PAD, or go directly to DONE if FRAME_BITS=MSG_W+1.
  - PAD: sample at the same cadence for k=MSG_W+1..FRAME_BITS-1. OR each sample into a sticky pad_err flag.
    - After sample k=FRAME_BITS-1, go to DONE.
  - DONE: lasts one cycle.
    - If pad_err=0: load msg_out from the shift register and assert msg_valid.
    - If pad_err=1: msg_out is unchanged and frame_err is asserted.
    - Clear pad_err and go to IDLE.
- Latency: the msg_valid or frame_err pulse is asserted in the cycle after the final sample.
  - That final sample occurs at t0+BIT_PERIOD/2+(FRAME_BITS-1)*BIT_PERIOD.
- msg_valid and frame_err are mutually exclusive and never high for more than one cycle.
- Back-to-back frames: IDLE is re-entered right after DONE. A new start bit is detected only on a fresh 0→1 edge of ser_s. A line held at 1 after a frame is not a start.
- Wrap-around: per_cnt resets to 0 at each sample point. bit_cnt never exceeds FRAME_BITS-1.
- Glitch rejection: a 1 shorter than BIT_PERIOD/2 clocks at the start position is rejected in START_CHK.

Test Plan:
- Use BIT_PERIOD=8, MSG_W=5, FRAME_BITS=10.
- Scenario 1: reset low for 3 cycles, then released, with ser_in=0 → all outputs 0, busy=0, no pulses for 100 cycles.
- Scenario 2: send frame 1,1,0,1,1,0,0,0,0,0 with each bit held 8 clocks → exactly one msg_valid pulse, msg_out=5'b10110, frame_err never high. Pulse timing is t0+77 (final sample at t0+76).
- Scenario 3: same message but pad bit 7 = 1 → one frame_err pulse, no msg_valid, msg_out holds its previous value 5'b10110.
- Scenario 4: a 2-clock high glitch on an idle line → busy rises, returns to IDLE at t0+4, no pulses. A valid frame for 5'b00001 immediately afterwards is received correctly.
- Scenario 5: two back-to-back frames, 5'b11111 then 5'b00000, with no idle gap beyond the pad bits → two msg_valid pulses, msg_out 5'b11111 then 5'b00000.
- Scenario 6: reset asserted during the DATA state of frame 5'b10101 → outputs return to 0 immediately, no pulse. The next full frame for 5'b01010 is received correctly.
